fetch_unit: RTL and testbench

//  RV32I instruction fetch stage; sits directly upstream of the instruction decoder.
//  - Holds the PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned words in a small FIFO and presents {instruccion, pc_out} to the decoder.
//  - Accepts redirects (taken branch, JAL, JALR) from the execute stage and flushes stale fetches.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage and the decoder.
// Holds the NOP encoding, reset PC default, fetch FSM states and base opcodes.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between memory return and the decoder.
// The head entry is kept in its own register so the output is flop-driven.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_nxt;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    w_rd_nxt;
  logic [PW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_cnt != '0);
  assign w_push = push && ((r_cnt != (PW+1)'(DEPTH)) || w_pop);

  assign w_rd_nxt = w_pop ? r_rd + PW'(1) : r_rd;

  // the next head may be the word being written this very cycle
  assign w_head_nxt = (w_push && (r_wr == w_rd_nxt)) ? wdata
                                                     : r_mem[w_rd_nxt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_head <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= wdata;
        r_wr        <= r_wr + PW'(1);
      end
      r_rd   <= w_rd_nxt;
      r_cnt  <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      r_head <= w_head_nxt;
    end
  end

  assign count = r_cnt;
  assign head  = r_head;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding imem handshake, redirect flush.
// Words land in fetch_fifo and are presented to the decoder as {instr, pc}.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = rv32i_pkg::DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instruccion,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_addr;
  logic [31:0]  r_last_pc;
  logic [31:0]  w_tgt;
  logic         w_push;
  logic         w_pop;
  logic         w_credit;
  logic         w_issue;
  logic [CW-1:0] w_count;
  fetch_entry_t w_wdata;
  fetch_entry_t w_head;

  assign w_tgt    = redirect_pc & ~32'd3;
  assign w_credit = (w_count < CW'(FIFO_DEPTH));
  assign w_issue  = (r_state == IDLE) && (w_state_nxt == WAIT);
  assign w_wdata  = '{pc: r_pc, instr: imem_rdata};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!redirect_valid && w_credit) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (redirect_valid) w_pc_nxt = w_tgt;
  end

  // imem_addr is latched separately so it stays put across a DISCARD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_last_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_issue) r_addr <= r_pc;
      if (instr_valid) r_last_pc <= w_head.pc;
    end
  end

  assign w_pop = instr_valid && !stall && !redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .flush (redirect_valid),
    .count (w_count),
    .head  (w_head)
  );

  assign imem_req    = (r_state != IDLE);
  assign imem_addr   = r_addr;
  assign instr_valid = (w_count != '0);
  assign instruccion = instr_valid ? w_head.instr : NOP_INSTR;
  assign pc_out      = instr_valid ? w_head.pc : r_last_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect/latency
// against a PC-stream model of what the decoder must see.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instruccion;
  logic [31:0] pc_out;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        iv2;
  logic [31:0] ins2;
  logic [31:0] pco2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid),
    .instruccion(instruccion), .pc_out(pc_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .stall(1'b0), .instr_valid(iv2),
    .instruccion(ins2), .pc_out(pco2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[26:2] ^ 25'h1A5_A5A5, 7'h13};
  endfunction

  int          age = 0;
  int          mem_lat = 1;
  int          n_req = 0;
  int          n_pop = 0;
  int          redir_when = 0;
  bit          mem_auto = 1'b1;
  bit          rnd = 1'b0;
  bit          stall_k = 1'b0;
  bit          ack_k = 1'b0;
  logic [31:0] tgt_k = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] addr_log[$];
  logic [31:0] a2[$];
  logic [31:0] p2[$];
  logic [31:0] i2[$];

  // memory responder, stimulus and decoder-side model, all on negedge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      age = 0;
      imem_ack = 1'b0;
      redirect_valid = 1'b0;
      exp_pc = RPC;
    end else begin
      if (!mem_auto) begin
        imem_ack = ack_k;
        ack_k = 1'b0;
        age = 0;
        imem_rdata = $urandom;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
        age = 0;
        imem_rdata = $urandom;
      end else if (imem_req) begin
        if (age == 0) begin
          n_req++;
          req_addr = imem_addr;
          addr_log.push_back(imem_addr);
          check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
          if (rnd) mem_lat = $urandom_range(1, 3);
        end else begin
          check("addr_hold", imem_addr, req_addr);
        end
        age++;
        if (age >= mem_lat + 1) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
        end
      end else begin
        age = 0;
      end

      redirect_valid = 1'b0;
      if (rnd) begin
        stall = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 24) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc = $urandom;
        end
      end else begin
        stall = stall_k;
        if (redir_when == 1 || (redir_when == 2 && imem_ack) ||
            (redir_when == 3 && imem_req && age == 1 && !imem_ack)) begin
          redirect_valid = 1'b1;
          redirect_pc = tgt_k;
          redir_when = 0;
        end
      end

      if (!instr_valid) begin
        check("nop_when_empty", instruccion, NOP);
      end else if (!stall && !redirect_valid) begin
        check("pop_pc", pc_out, exp_pc);
        check("pop_instr", instruccion, mem_word(exp_pc));
        exp_pc += 32'd4;
        n_pop++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
    end
  end

  // one-cycle memory for the wrap instance
  initial begin
    bit seen2;
    seen2 = 1'b0;
    forever begin
      @(negedge clk);
      if (iv2) begin
        p2.push_back(pco2);
        i2.push_back(ins2);
      end
      if (rst) begin
        ack2 = 1'b0;
        seen2 = 1'b0;
      end else if (ack2) begin
        ack2 = 1'b0;
        seen2 = 1'b0;
      end else if (req2 && seen2) begin
        ack2 = 1'b1;
        rdata2 = mem_word(addr2);
      end else if (req2) begin
        seen2 = 1'b1;
        a2.push_back(addr2);
      end
    end
  end

  task automatic wait_knob(input string tag);
    int k;
    k = 0;
    while (redir_when != 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(redir_when), 32'd0);
  endtask

  task automatic wait_new_req(input int n0, input string tag);
    int k;
    k = 0;
    while (n_req <= n0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, 32'(n_req > n0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int p0;
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruccion, NOP);
    check("rst_pcout", pc_out, 32'd0);
    rst = 1'b0;

    @(posedge clk); #1;
    check("t1_req_e1", 32'(imem_req), 32'd1);
    check("t1_valid_e1", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_e2", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_e3", 32'(instr_valid), 32'd1);
    check("t1_pcout0", pc_out, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t1_addr_seq", (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF,
            32'(i * 4));
      check("t5_wrap_addr", (i < a2.size()) ? a2[i] : 32'hDEAD_BEEF, wexp[i]);
    end
    check("t5_wrap_pc", (p2.size() > 2) ? p2[2] : 32'hDEAD_BEEF, 32'd0);
    check("t5_wrap_instr", (i2.size() > 2) ? i2[2] : 32'hDEAD_BEEF,
          mem_word(32'd0));

    stall_k = 1'b1;
    tgt_k = 32'h0000_0200;
    redir_when = 1;
    wait_knob("t2_redirect");
    n0 = n_req;
    repeat (12) @(posedge clk);
    #1;
    check("t2_nreq", 32'(n_req - n0), 32'(DEPTH));
    check("t2_req_low", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_head_pc", pc_out, 32'h0000_0200);
    stall_k = 1'b0;
    p0 = n_pop;
    repeat (12) @(posedge clk);
    #1;
    check("t2_drain", 32'(n_pop - p0 >= DEPTH), 32'd1);

    mem_lat = 3;
    tgt_k = 32'h0000_0103;
    redir_when = 3;
    wait_knob("t3_redirect");
    n0 = n_req;
    check("t3_flushed", 32'(instr_valid), 32'd0);
    wait_new_req(n0, "t3_new_req");
    check("t3_addr", req_addr, 32'h0000_0100);
    check("t3_empty", 32'(instr_valid), 32'd0);
    check("t3_nop", instruccion, NOP);
    repeat (10) @(posedge clk);

    mem_lat = 1;
    tgt_k = 32'h0000_0300;
    redir_when = 2;
    wait_knob("t4_redirect");
    n0 = n_req;
    check("t4_no_push", 32'(instr_valid), 32'd0);
    wait_new_req(n0, "t4_new_req");
    check("t4_addr", req_addr, 32'h0000_0300);
    repeat (10) @(posedge clk);

    mem_auto = 1'b0;
    n0 = 0;
    while (!imem_req && n0 < 50) begin
      @(posedge clk); #1;
      n0++;
    end
    check("t6_outstanding", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_req", 32'(imem_req), 32'd0);
    check("t6_addr", imem_addr, RPC);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_instr", instruccion, NOP);
    check("t6_pcout", pc_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_k = 1'b1;
    @(posedge clk); #1;
    check("t6_restart_req", 32'(imem_req), 32'd1);
    check("t6_restart_addr", imem_addr, RPC);
    repeat (3) @(posedge clk);
    #1;
    check("t6_late_ack", 32'(instr_valid), 32'd0);
    p0 = n_pop;
    mem_auto = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t6_resume", 32'(n_pop > p0), 32'd1);

    p0 = n_pop;
    rnd = 1'b1;
    repeat (4000) @(posedge clk);
    #1;
    rnd = 1'b0;
    check("rnd_progress", 32'(n_pop > p0 + 200), 32'd1);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
